game_hex_ctrl: RTL and testbench
================================

# game_hex_ctrl

Parametrised Avalon-MM seven-segment display controller for the game's HEX bank. It supports 1–8 digits and per-digit hex-decode or raw-segment mode. A free-running blink timer flashes selected digits, and the whole bank can be blanked. The Nios II software writes nibbles instead of segment patterns. The block sits on the system interconnect as a slave and drives the board HEX pins directly.

## Interface
- DIGITS, 4: number of digits, legal 1..8.
- BLINK_DIV, 25000000: clock cycles per blink half-period, legal ≥2.
- ACTIVE_LOW, 1: 1 inverts segment outputs (lit = 0), 0 drives lit = 1.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational.
- out_port  out  DIGITS*7  segments, digit d at [7d+6:7d], bit0=a … bit6=g.

## Operation
- Write strobe: chipselect && ~write_n at a rising clk edge.
  - Unused addresses are ignored.
  - Bits beyond the implemented width are ignored and read 0.
- Register map (reset value in brackets):
  - 0 VALUE [0]: nibble per digit, digit d at [4d+3:4d], DIGITS*4 bits.
  - 1 MODE [0]: bit d=1 → digit d shows RAW pattern; 0 → hex-decoded VALUE nibble.
  - 2 BLINK [0]: bit d=1 → digit d blinks when blink is enabled.
  - 3 RAW_LO [0]: raw patterns for digits 0..3, 7 bits each, [27:0].
  - 4 RAW_HI [0]: raw patterns for digits 4..7, [27:0]. Only present for DIGITS>4; otherwise writes are ignored.
  - 5 CTRL [0b10]: bit0 BLINK_EN, bit1 BLANK.
  - 6 STATUS, read-only: bit0 current blink phase.
- Hex decode (lit = 1): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- Blink timer:
  - While BLINK_EN=1, a counter runs 0..BLINK_DIV-1. At the terminal count it wraps to 0 and toggles the phase.
  - While BLINK_EN=0, the counter and phase are held at 0 synchronously.
  - Counter width is ceil(log2(BLINK_DIV)).
- Per-digit pattern, in priority order:
  1. BLANK=1 → 0.
  2. BLINK[d] && phase=1 → 0.
  3. MODE[d] → RAW pattern.
  4. Otherwise → decode(VALUE nibble).
- out_port is registered. It equals the per-digit pattern, XOR all-ones when ACTIVE_LOW=1.
- A write to CTRL that sets BLINK_EN=0 also clears the phase on that same edge.

## Timing
- Register writes take effect at the write edge N. out_port reflects the change at edge N+1.
- Blink phase toggles every BLINK_DIV cycles once enabled. The first toggle occurs BLINK_DIV cycles after the edge that sets BLINK_EN.
- readdata is combinational from the current address and register contents, with zero wait states.
- Reset, asserted at any time including mid-blink:
  - All registers go to their reset values and the counter and phase go to 0.
  - out_port goes to all ones (ACTIVE_LOW=1) or all zeros (ACTIVE_LOW=0), i.e. dark, immediately and asynchronously.
- Simultaneous blink wrap and CTRL write clearing BLINK_EN: the clear wins, so phase=0.

## Configuration
- GAME_HEX_CTRL_READBACK_EN:
  - Defined: readdata returns the addressed register (addresses 0–6), zero-extended, and 0 for unused addresses.
  - Undefined: readdata is constant 0 and the STATUS register is not implemented. Blink and write behaviour are unchanged.

## Test plan
- Reset dark: with DIGITS=4 and ACTIVE_LOW=1, assert reset_n=0 → out_port=0xFFFFFFF. After release, write CTRL=0 → one cycle later digit 0 shows ~0x3F=0x40 and out_port=0x8102040.
- Hex decode: with CTRL=0, write VALUE=0x00001234. On the cycle after the write, expect out_port [6:0]=~0x66, [13:7]=~0x4F, [20:14]=~0x5B, [27:21]=~0x06.
- Raw mode: write RAW_LO[6:0]=0x49 and MODE=0x1 → digit 0 = ~0x49 and the other digits stay decoded. Then MODE=0 → digit 0 returns to decode.
- Blink: with BLINK_DIV=4, write BLINK=0x2 and CTRL=0x1.
  - Digit 1 goes dark (~0x00) for 4 cycles, then lit for 4 cycles, repeating. Other digits are steady.
  - STATUS bit0 toggles in step.
  - Writing CTRL=0 mid-dark-phase → digit 1 is lit on the next output update and STATUS=0.
- Blank override: set BLANK=1 with MODE and BLINK active → all digits dark. Clearing BLANK restores the previous display.
- Readback (READBACK_EN): write VALUE=0xFFFFFFFF with DIGITS=4 → reads 0x0000FFFF. A read of address 7 returns 0. Without the macro, every read returns 0.

Source files
------------

// File: rtl/game_hex_ctrl.sv
// rtl/game_hex_ctrl.sv - Avalon-MM seven-segment HEX bank controller with hex decode, raw mode, blink and blank
// Optional register readback is enabled by defining GAME_HEX_CTRL_READBACK_EN.
module game_hex_ctrl #(
    parameter int DIGITS     = 4,
    parameter int BLINK_DIV  = 25000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DIGITS*7-1:0]   out_port
);
    localparam int              CW       = $clog2(BLINK_DIV);
    localparam int              SW       = DIGITS * 7;
    localparam logic [CW-1:0]   CNT_LAST = CW'(BLINK_DIV - 1);
    localparam logic [SW-1:0]   DARK     = {SW{ACTIVE_LOW}};

    logic [DIGITS*4-1:0] value;
    logic [DIGITS-1:0]   mode;
    logic [DIGITS-1:0]   blink;
    logic [SW-1:0]       raw;
    logic [SW-1:0]       raw_nxt;
    logic [SW-1:0]       pattern;
    logic                blink_en;
    logic                blank;
    logic                phase;
    logic [CW-1:0]       cnt;
    logic                wr;
    logic                unused_writedata;

    assign wr               = chipselect && !write_n;
    assign unused_writedata = ^writedata;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        case (n)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // RAW_LO feeds digits 0..3 and RAW_HI digits 4..7, both packed 7 bits per digit from bit 0
    always_comb begin
        raw_nxt = raw;
        for (int d = 0; d < DIGITS; d++) begin
            if (wr && ((address == 3'd3 && d < 4) || (address == 3'd4 && d >= 4)))
                raw_nxt[7*d +: 7] = writedata[7*(d%4) +: 7];
        end
    end

    always_comb begin
        pattern = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (blank || (blink[d] && phase))
                pattern[7*d +: 7] = 7'h00;
            else if (mode[d])
                pattern[7*d +: 7] = raw[7*d +: 7];
            else
                pattern[7*d +: 7] = hex_decode(value[4*d +: 4]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value    <= '0;
            mode     <= '0;
            blink    <= '0;
            raw      <= '0;
            blink_en <= 1'b0;
            blank    <= 1'b1;
            cnt      <= '0;
            phase    <= 1'b0;
            out_port <= DARK;
        end else begin
            raw      <= raw_nxt;
            out_port <= pattern ^ DARK;
            if (wr) begin
                case (address)
                    3'd0: value <= writedata[DIGITS*4-1:0];
                    3'd1: mode  <= writedata[DIGITS-1:0];
                    3'd2: blink <= writedata[DIGITS-1:0];
                    3'd5: begin
                        blink_en <= writedata[0];
                        blank    <= writedata[1];
                    end
                    default: ;
                endcase
            end
            // A CTRL write disabling blink beats a simultaneous terminal-count toggle
            if (wr && address == 3'd5 && !writedata[0]) begin
                cnt   <= '0;
                phase <= 1'b0;
            end else if (!blink_en) begin
                cnt   <= '0;
                phase <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt   <= cnt + CW'(1);
            end
        end
    end

`ifdef GAME_HEX_CTRL_READBACK_EN
    logic [31:0] raw_lo;
    logic [31:0] raw_hi;

    always_comb begin
        raw_lo = '0;
        raw_hi = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (d < 4)
                raw_lo[7*(d%4) +: 7] = raw[7*d +: 7];
            else
                raw_hi[7*(d%4) +: 7] = raw[7*d +: 7];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata = 32'(value);
            3'd1:    readdata = 32'(mode);
            3'd2:    readdata = 32'(blink);
            3'd3:    readdata = raw_lo;
            3'd4:    readdata = raw_hi;
            3'd5:    readdata = {30'd0, blank, blink_en};
            3'd6:    readdata = {31'd0, phase};
            default: readdata = '0;
        endcase
    end
`else
    assign readdata = '0;
`endif

endmodule

// File: tb/tb_game_hex_ctrl.sv
// tb/tb_game_hex_ctrl.sv - randomized self-checking bench for game_hex_ctrl against a behavioural model
module tb_game_hex_ctrl;
    localparam int ND = 4;
    localparam int BD = 4;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [2:0]  address    = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'd0;
    logic [31:0] readdata;
    logic [27:0] out_port;

    always #5 clk = ~clk;

    game_hex_ctrl #(.DIGITS(ND), .BLINK_DIV(BD), .ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0]  m_value [ND];
    logic [6:0]  m_raw   [ND];
    logic [3:0]  m_mode;
    logic [3:0]  m_blink;
    logic        m_en;
    logic        m_blank;
    logic        m_phase;
    int          edge_cnt = 0;
    int          en_edge  = 0;
    logic [27:0] exp_out;

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_value[d] = 4'h0;
            m_raw[d]   = 7'h00;
        end
        m_mode  = '0;
        m_blink = '0;
        m_en    = 1'b0;
        m_blank = 1'b1;
        m_phase = 1'b0;
        exp_out = 28'hFFFFFFF;
    endtask

    function automatic logic [27:0] model_out();
        logic [27:0] o;
        logic [6:0]  s;
        o = '0;
        for (int d = 0; d < ND; d++) begin
            if (m_blank)                      s = 7'h00;
            else if (m_blink[d] && m_phase)   s = 7'h00;
            else if (m_mode[d])               s = m_raw[d];
            else                              s = seg_tab[m_value[d]];
            o[7*d +: 7] = ~s;
        end
        return o;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
`ifdef GAME_HEX_CTRL_READBACK_EN
        case (a)
            3'd0:    return {16'd0, m_value[3], m_value[2], m_value[1], m_value[0]};
            3'd1:    return {28'd0, m_mode};
            3'd2:    return {28'd0, m_blink};
            3'd3:    return {4'd0, m_raw[3], m_raw[2], m_raw[1], m_raw[0]};
            3'd5:    return {30'd0, m_blank, m_en};
            3'd6:    return {31'd0, m_phase};
            default: return 32'd0;
        endcase
`else
        return (a == 3'd7) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Output seen after an edge is the pattern of the state before it; phase follows elapsed enabled time
    task automatic model_edge(input logic wr, input logic [2:0] a, input logic [31:0] wd);
        edge_cnt++;
        exp_out = model_out();
        if (wr) begin
            case (a)
                3'd0: for (int d = 0; d < ND; d++) m_value[d] = wd[4*d +: 4];
                3'd1: m_mode  = wd[3:0];
                3'd2: m_blink = wd[3:0];
                3'd3: for (int d = 0; d < ND; d++) m_raw[d] = wd[7*d +: 7];
                3'd5: begin
                    if (wd[0] && !m_en) en_edge = edge_cnt;
                    m_en    = wd[0];
                    m_blank = wd[1];
                end
                default: ;
            endcase
        end
        m_phase = m_en ? ((((edge_cnt - en_edge) / BD) % 2) == 1) : 1'b0;
    endtask

    task automatic cycle(input logic cs, input logic wn, input logic [2:0] a,
                         input logic [31:0] wd, input string tag);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        model_edge(cs && !wn, a, wd);
        #1;
        check({tag, "_out"}, 32'(out_port), 32'(exp_out));
        check({tag, "_rd"}, readdata, model_read(a));
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, 1'b1, 3'd6, 32'd0, tag);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_out", 32'(out_port), 32'h0FFFFFFF);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd5;
        #1;
        check("rst_ctrl_rd", readdata, model_read(3'd5));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [2:0]  a;
        logic [31:0] wd;
        model_reset();
        do_reset();

        cycle(1'b1, 1'b0, 3'd5, 32'd0, "ctrl0");
        idle("lit0");
        check("dark_to_lit", 32'(out_port), 32'h08102040);

        cycle(1'b1, 1'b0, 3'd0, 32'h00001234, "val");
        idle("val_upd");
        check("hex_d0", 32'(out_port[6:0]),   32'h19);
        check("hex_d1", 32'(out_port[13:7]),  32'h30);
        check("hex_d2", 32'(out_port[20:14]), 32'h24);
        check("hex_d3", 32'(out_port[27:21]), 32'h79);

        cycle(1'b1, 1'b0, 3'd3, 32'h00000049, "raw");
        cycle(1'b1, 1'b0, 3'd1, 32'h00000001, "mode1");
        idle("raw_upd");
        check("raw_d0", 32'(out_port[6:0]), 32'h36);
        cycle(1'b1, 1'b0, 3'd1, 32'h00000000, "mode0");
        idle("dec_upd");
        check("dec_d0", 32'(out_port[6:0]), 32'h19);

        cycle(1'b1, 1'b0, 3'd2, 32'h00000002, "blink");
        cycle(1'b1, 1'b0, 3'd5, 32'h00000001, "ben");
        for (int i = 0; i < 12; i++) idle("blinking");
        for (int i = 0; i < 8 && !m_phase; i++) idle("seek_dark");
        cycle(1'b1, 1'b0, 3'd5, 32'h00000000, "ben_off");
        idle("off_upd");
        check("blink_off_lit", 32'(out_port[13:7]), 32'h30);

        cycle(1'b1, 1'b0, 3'd1, 32'h00000001, "mode_bl");
        cycle(1'b1, 1'b0, 3'd5, 32'h00000003, "blank_on");
        for (int i = 0; i < 6; i++) idle("blanked");
        check("blank_all", 32'(out_port), 32'h0FFFFFFF);
        cycle(1'b1, 1'b0, 3'd5, 32'h00000001, "blank_off");
        for (int i = 0; i < 6; i++) idle("unblanked");

        cycle(1'b1, 1'b0, 3'd0, 32'hFFFFFFFF, "val_ff");
        cycle(1'b0, 1'b1, 3'd0, 32'd0, "rd_val");
`ifdef GAME_HEX_CTRL_READBACK_EN
        check("rb_value", readdata, 32'h0000FFFF);
`else
        check("rb_value", readdata, 32'h00000000);
`endif
        cycle(1'b0, 1'b1, 3'd7, 32'd0, "rd_addr7");
        check("rb_addr7", readdata, 32'h00000000);

        for (int i = 0; i < 5; i++) idle("pre_rst");
        do_reset();
        for (int i = 0; i < 3; i++) idle("post_rst");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd5) wd[1] = ($urandom_range(0, 3) == 0);
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), a, wd, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
